// File: rtl/uart_receiver_pkg.sv
// Shared constants and types for the memory-mapped UART receiver.
package uart_receiver_pkg;

    // One-hot word-address bits inside the SOC IO page
    localparam int IO_UART_RX_DAT_bit  = 3;
    localparam int IO_UART_RX_CNTL_bit = 4;

    // Field positions inside the 32-bit read word
    localparam int RD_BYTE_LSB       = 0;
    localparam int RD_BYTE_MSB       = 7;
    localparam int RD_VALID_BIT      = 8;
    localparam int RD_OVERRUN_BIT    = 9;
    localparam int RD_FRAME_ERR_BIT  = 10;

    typedef logic [31:0] rd_word_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Build the processor-visible status/data word; upper bits read as zero
    function automatic rd_word_t pack_rd_data(input logic frame_err, input logic overrun,
                                              input logic valid, input logic [7:0] data);
        rd_word_t w;
        w = '0;
        w[RD_BYTE_MSB:RD_BYTE_LSB] = data;
        w[RD_VALID_BIT]            = valid;
        w[RD_OVERRUN_BIT]          = overrun;
        w[RD_FRAME_ERR_BIT]        = frame_err;
        return w;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Processor-side read port of the UART receiver: read strobe, registered
// read word, and the live non-empty status.
interface uart_receiver_if
    import uart_receiver_pkg::*;
;
    logic     rd_en;
    rd_word_t rd_data;
    logic     rx_valid;

    modport master (output rd_en, input  rd_data, input  rx_valid);
    modport slave  (input  rd_en, output rd_data, output rx_valid);
endinterface

// File: rtl/uart_rx_buffer.sv
// Receive byte buffer. Define UART_RX_FIFO_EN for a 4-entry circular FIFO;
// otherwise a single holding register with a valid bit is built.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_buffer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    logic wr_en;
    logic rd_ok;

    assign wr_en = push && (!full || pop);
    assign rd_ok = pop && !empty;

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    assign head  = mem[rd_ptr];
    assign empty = (count == 3'd0);
    assign full  = (count == 3'd4);

    // Pointer and occupancy bookkeeping; 2-bit pointers wrap 3 -> 0 naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (rd_ok) rd_ptr <= rd_ptr + 2'd1;
            count <= count + 3'(wr_en) - 3'(rd_ok);
        end
    end

    // Storage; when full with a pop, the write lands in the slot being vacated
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end
`else
    logic [7:0] hold;
    logic       hold_vld;

    assign head  = hold;
    assign empty = !hold_vld;
    assign full  = hold_vld;

    // Single holding register; a simultaneous push/pop replaces the byte
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (wr_en) begin
            hold     <= push_data;
            hold_vld <= 1'b1;
        end else if (rd_ok) begin
            hold_vld <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_receiver.sv
// UART receiver top: RXD synchronizer, frame FSM, sticky error flags and the
// registered read word. Buffer depth is selected by UART_RX_FIFO_EN (see
// uart_rx_buffer). CLK_FREQ_HZ / BAUD_RATE must be at least 4.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            rxd,
    uart_receiver_if.slave  bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_m, rx_s;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, cnt_nxt;
    logic [2:0]       bit_idx, idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             push, frame_set;
    logic             frame_err, overrun;
    logic             pop, empty, full;
    logic [7:0]       head;
    rd_word_t         rd_data;

    // Two-flop synchronizer; idle-high reset so reset never looks like a start bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
        end
    end

    // Frame FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RX_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            clk_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // Next-state: mid-bit sampling driven by a down-counter reloaded per bit
    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            RX_START: begin
                if (clk_cnt != '0) begin
                    cnt_nxt = clk_cnt - 1'b1;
                end else if (!rx_s) begin
                    state_nxt = RX_DATA;
                    cnt_nxt   = CNT_BIT;
                    idx_nxt   = 3'd0;
                end else begin
                    state_nxt = RX_IDLE;    // glitch shorter than half a bit
                end
            end
            RX_DATA: begin
                if (clk_cnt != '0) begin
                    cnt_nxt = clk_cnt - 1'b1;
                end else begin
                    shift_nxt = {rx_s, shift[7:1]};   // LSB arrives first
                    cnt_nxt   = CNT_BIT;
                    idx_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt != '0) begin
                    cnt_nxt = clk_cnt - 1'b1;
                end else if (rx_s) begin
                    push      = 1'b1;
                    state_nxt = RX_IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_nxt = RX_BREAK;
                end
            end
            RX_BREAK: begin
                // A held-low line must return high before another frame starts
                if (rx_s) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign pop = bus.rd_en && !empty;

    uart_rx_buffer u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

    // Sticky flags clear on any read; a same-cycle set from the FSM wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_set | (frame_err & ~bus.rd_en);
            overrun   <= (push & full & ~pop) | (overrun & ~bus.rd_en);
        end
    end

    // Read word captured on the strobe and held until the next strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (bus.rd_en) begin
            rd_data <= pack_rd_data(frame_err, overrun, !empty, empty ? 8'h00 : head);
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rx_valid = !empty;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 12 clocks per bit. Frames are
// serialised bit by bit; a queue model of the receive buffer plus sticky
// flags predicts every read word.
module tb_uart_receiver;

    localparam int CPB = 12;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic rxd    = 1'b1;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLK_FREQ_HZ (12_000_000),
        .BAUD_RATE   (1_000_000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .rxd    (rxd),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m_q [$];
    logic        m_ferr;
    logic        m_ovr;
    logic [31:0] e_sim;
    logic [7:0]  rb;
    logic        rok;
    int          nf, nr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Model: a good frame enters the buffer unless it is full; a bad stop bit only flags
    function automatic void m_frame(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)                 m_ferr = 1'b1;
        else if (m_q.size() < DEPTH)  m_q.push_back(b);
        else                          m_ovr = 1'b1;
    endfunction

    function automatic logic [31:0] m_read();
        logic [31:0] r;
        r     = '0;
        r[10] = m_ferr;
        r[9]  = m_ovr;
        if (m_q.size() > 0) begin
            r[8]   = 1'b1;
            r[7:0] = m_q.pop_front();
        end
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        return r;
    endfunction

    // Call at a negedge; returns at the negedge ending the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic rd_chk(input string tag);
        logic [31:0] e;
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'(m_q.size() > 0));
        e = m_read();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk(tag, bus.rd_data, e);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rd_en = 1'b0;
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame; rx_valid must rise right after the stop-bit sample
        fork
            send_frame(8'h41, 1'b1);
            begin
                repeat (116) @(negedge clk);
                chk("valid_pre_stop", 32'(bus.rx_valid), 32'h0);
                @(negedge clk);
                chk("valid_at_stop", 32'(bus.rx_valid), 32'h1);
            end
        join
        m_frame(8'h41, 1'b1);
        rd_chk("single");
        chk("single_lit", bus.rd_data, 32'h0000_0141);
        chk("single_empty", 32'(bus.rx_valid), 32'h0);
        repeat (5) @(negedge clk);
        chk("rd_hold", bus.rd_data, 32'h0000_0141);

        // Glitch shorter than half a bit
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        rd_chk("glitch");

        // Framing error, line held low, then a good frame
        send_frame(8'h55, 1'b0);
        m_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1);
        m_frame(8'h12, 1'b1);
        rd_chk("ferr_1");
        chk("ferr_1_lit", bus.rd_data, 32'h0000_0512);
        rd_chk("ferr_2");

        // Overflow: one more back-to-back frame than the buffer holds
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1);
            m_frame(8'(i), 1'b1);
        end
        for (int i = 0; i <= DEPTH; i++) rd_chk("ovf");

        // Reset in the middle of data bit 3 with a byte buffered
        send_frame(8'hA5, 1'b1);
        m_frame(8'hA5, 1'b1);
        rd_chk("pre_rst");
        send_frame(8'h3C, 1'b1);
        m_frame(8'h3C, 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = 1'(8'hC3 >> i);
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("async_rst_rd_data", bus.rd_data, 32'h0);
        chk("async_rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        rxd = 1'b1;
        m_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        m_frame(8'h7E, 1'b1);
        rd_chk("post_rst");
        chk("post_rst_lit", bus.rd_data, 32'h0000_017E);

        // Pop in exactly the cycle a new byte is pushed into a full buffer
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'hA0 + 8'(i), 1'b1);
            m_frame(8'hA0 + 8'(i), 1'b1);
        end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (116) @(negedge clk);
                bus.rd_en = 1'b1;
                e_sim = m_read();
                @(negedge clk);
                bus.rd_en = 1'b0;
                chk("simul_rd", bus.rd_data, e_sim);
            end
        join
        m_frame(8'h5A, 1'b1);
        chk("simul_full", 32'(bus.rx_valid), 32'h1);
        for (int i = 0; i <= DEPTH; i++) rd_chk("simul_drain");

        // Randomized frames, bad stop bits and reads
        for (int it = 0; it < 25; it++) begin
            nf = int'($urandom_range(0, DEPTH + 1));
            for (int f = 0; f < nf; f++) begin
                rb  = 8'($urandom);
                rok = ($urandom_range(0, 7) != 0);
                send_frame(rb, rok);
                m_frame(rb, rok);
                if (!rok) begin
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                    rxd = 1'b1;
                    repeat (3) @(negedge clk);
                end
            end
            if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 20)) @(negedge clk);
            nr = int'($urandom_range(1, DEPTH + 1));
            for (int r = 0; r < nr; r++) rd_chk("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
